// File: rtl/simon_control_if.sv
// Status/strobe bundle between the Simon controller (master) and its datapath (slave).
interface simon_control_if;
    logic       legal;
    logic       right_guess;
    logic       i_eq_ns;
    logic       count_ns;
    logic       count_i;
    logic       rst_i;
    logic       reset;
    logic       m1;
    logic       m2;
    logic       m3;
    logic       m4;
    logic [2:0] mode_leds;

    modport master (
        input  legal, right_guess, i_eq_ns,
        output count_ns, count_i, rst_i, reset, m1, m2, m3, m4, mode_leds
    );

    modport slave (
        output legal, right_guess, i_eq_ns,
        input  count_ns, count_i, rst_i, reset, m1, m2, m3, m4, mode_leds
    );
endinterface

// File: rtl/simon_control.sv
// Simon game controller: INPUT -> PLAYBACK -> REPEAT rounds, DONE on loss or full memory.
// Optional SIMON_STATE_OUT_EN exposes the raw state encoding on state_dbg.
module simon_control #(
    parameter int MEM_DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    simon_control_if.master      bus
`ifdef SIMON_STATE_OUT_EN
    ,
    output logic [1:0]           state_dbg
`endif
);
    localparam int ROUND_W = $clog2(MEM_DEPTH) + 1;

    typedef enum logic [1:0] {
        INPUT    = 2'd0,
        PLAYBACK = 2'd1,
        REPEAT   = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [ROUND_W-1:0] round;
    logic               full;

    assign full      = (round == ROUND_W'(MEM_DEPTH));
    assign bus.reset = rst;

`ifdef SIMON_STATE_OUT_EN
    assign state_dbg = state;
`endif

    // count_ns is never raised while full, so round saturates at MEM_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INPUT;
            round <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state <= next_state;
            if (bus.count_ns) round <= round + ROUND_W'(1);
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state    = state;
        bus.count_ns  = 1'b0;
        bus.count_i   = 1'b0;
        bus.rst_i     = 1'b0;
        bus.m1        = 1'b0;
        bus.m2        = 1'b0;
        bus.m3        = 1'b0;
        bus.m4        = 1'b0;
        bus.mode_leds = 3'b001;

        case (state)
            INPUT: begin
                bus.mode_leds = 3'b001;
                if (full) begin
                    bus.rst_i  = 1'b1;
                    next_state = DONE;
                end else if (bus.legal) begin
                    bus.m1       = 1'b1;
                    bus.count_ns = 1'b1;
                    bus.rst_i    = 1'b1;
                    next_state   = PLAYBACK;
                end
            end
            PLAYBACK: begin
                bus.mode_leds = 3'b010;
                bus.m2        = 1'b1;
                bus.m3        = 1'b1;
                if (bus.i_eq_ns) begin
                    bus.rst_i  = 1'b1;
                    next_state = REPEAT;
                end else begin
                    bus.count_i = 1'b1;
                end
            end
            REPEAT: begin
                bus.mode_leds = 3'b100;
                bus.m3        = 1'b1;
                bus.m4        = 1'b1;
                // A wrong guess on the last entry is still a loss.
                if (!bus.right_guess) begin
                    bus.rst_i  = 1'b1;
                    next_state = DONE;
                end else if (bus.i_eq_ns) begin
                    bus.rst_i  = 1'b1;
                    next_state = INPUT;
                end else begin
                    bus.count_i = 1'b1;
                end
            end
            DONE: begin
                bus.mode_leds = 3'b111;
                bus.m2        = 1'b1;
                bus.m3        = 1'b1;
                if (bus.i_eq_ns) bus.rst_i   = 1'b1;
                else             bus.count_i = 1'b1;
            end
            default: begin
                next_state = INPUT;
            end
        endcase

        // The state register is already INPUT under reset; strobes must stay quiet too.
        if (rst) begin
            next_state   = INPUT;
            bus.count_ns = 1'b0;
            bus.count_i  = 1'b0;
            bus.rst_i    = 1'b0;
            bus.m1       = 1'b0;
            bus.m2       = 1'b0;
            bus.m3       = 1'b0;
            bus.m4       = 1'b0;
        end
    end
endmodule
